// File: rtl/fabric_cfg_ctrl.sv
// Wishbone configuration controller for the v_line mux fabric.
// A configuration change gates all pad OEs, drains, switches the mux select, settles, then releases the pads.
module fabric_cfg_ctrl #(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter logic [3:0]  RESET_CFG  = 4'd0,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  configuration,
  output logic        oe_block,
  output logic        cfg_busy
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_pending;
  logic [7:0]  r_drain;
  logic [7:0]  r_switch_cnt;
  logic [7:0]  r_gate_cnt;
  logic [3:0]  r_settle_cnt;
  logic        r_err;

  logic        w_req;
  logic        w_wr;
  logic [7:0]  w_off;
  logic        w_cfg_wr;
  logic        w_cfg_ok;
  logic        w_drain_wr;
  logic        w_errclr;
  logic [3:0]  w_pending_nxt;
  logic [7:0]  w_drain_ld;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  // The !ack term limits the slave to one ack every two cycles.
  assign w_req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign w_wr       = w_req & wbs_we_i;
  assign w_off      = wbs_adr_i[7:0];
  assign w_cfg_wr   = w_wr & (w_off == 8'h00) & wbs_sel_i[0];
  assign w_cfg_ok   = w_cfg_wr & (wbs_dat_i[3:2] == 2'b00);
  assign w_drain_wr = w_wr & (w_off == 8'h08) & wbs_sel_i[0];
  assign w_errclr   = w_wr & (w_off == 8'h0C) & wbs_dat_i[0];

  // Sequencer decisions look at the pending value being written this edge.
  assign w_pending_nxt = w_cfg_ok ? wbs_dat_i[3:0] : r_pending;
  assign w_drain_ld    = (r_drain == 8'd0) ? 8'd1 : r_drain;
  assign w_status      = {16'd0, r_switch_cnt, configuration, 1'b0, r_err,
                          (r_pending != configuration), cfg_busy};
  assign w_unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

  // Read data mux
  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      8'h00:   w_rdata = {28'd0, r_pending};
      8'h04:   w_rdata = w_status;
      8'h08:   w_rdata = {24'd0, r_drain};
      default: w_rdata = 32'd0;
    endcase
  end

  // Bus response and register file
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      r_pending <= RESET_CFG;
      r_drain   <= 8'd2;
      r_err     <= 1'b0;
    end else begin
      wbs_ack_o <= w_req;
      wbs_dat_o <= (w_req & ~wbs_we_i) ? w_rdata : 32'd0;
      r_pending <= w_pending_nxt;
      if (w_drain_wr) begin
        r_drain <= wbs_dat_i[7:0];
      end else begin
        r_drain <= r_drain;
      end
      if (w_cfg_wr & ~w_cfg_ok) begin
        r_err <= 1'b1;
      end else if (w_errclr) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // Change sequencer with registered pad-gate and busy outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state       <= IDLE;
      r_gate_cnt    <= 8'd0;
      r_settle_cnt  <= 4'd0;
      r_switch_cnt  <= 8'd0;
      configuration <= RESET_CFG;
      oe_block      <= 1'b0;
      cfg_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending_nxt != configuration) begin
            r_state    <= GATE;
            r_gate_cnt <= w_drain_ld;
            oe_block   <= 1'b1;
            cfg_busy   <= 1'b1;
          end else begin
            oe_block   <= 1'b0;
            cfg_busy   <= 1'b0;
          end
        end
        GATE: begin
          if (r_gate_cnt == 8'd1) begin
            r_state    <= SWITCH;
          end else begin
            r_gate_cnt <= r_gate_cnt - 8'd1;
          end
        end
        SWITCH: begin
          configuration <= r_pending;
          r_switch_cnt  <= r_switch_cnt + 8'd1;
          r_settle_cnt  <= SETTLE_LD;
          r_state       <= SETTLE;
        end
        SETTLE: begin
          if (r_settle_cnt != 4'd1) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end else if (w_pending_nxt != configuration) begin
            r_state    <= GATE;
            r_gate_cnt <= w_drain_ld;
          end else begin
            r_state    <= IDLE;
            oe_block   <= 1'b0;
            cfg_busy   <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          oe_block <= 1'b0;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_cfg_ctrl.sv
// Self-checking bench for fabric_cfg_ctrl: directed scenarios plus random bus traffic
// compared against a timeline model of the change sequence.
module tb_fabric_cfg_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          S    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat = 32'd0, adr = 32'd0;
  logic        ack, oe, busy;
  logic [31:0] rdat;
  logic [3:0]  cfg;

  int total = 0;
  int bad   = 0;

  // Model: register values plus the absolute edge numbers at which the
  // running sequence switches the configuration and releases the pads.
  int          edge_n = 0;
  logic [3:0]  m_pend, m_cfg;
  logic [7:0]  m_drain, m_cnt;
  bit          m_err, m_active, m_ack;
  int          m_switch_at, m_release_at;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  fabric_cfg_ctrl #(.BASE_ADR(BASE), .RESET_CFG(4'd0), .SETTLE_CYC(S)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .configuration(cfg), .oe_block(oe), .cfg_busy(busy)
  );

  task automatic model_reset();
    m_pend = 4'd0; m_cfg = 4'd0; m_drain = 8'd2; m_cnt = 8'd0;
    m_err = 0; m_active = 0; m_ack = 0; m_rd = 32'd0;
  endtask

  task automatic model_start(input logic [7:0] d);
    int dd;
    dd = (d == 8'd0) ? 1 : int'(d);
    m_active     = 1;
    m_switch_at  = edge_n + dd + 1;
    m_release_at = m_switch_at + S;
  endtask

  task automatic model_edge();
    logic [3:0] old_pend;
    logic [7:0] old_drain, off;
    bit req;
    old_pend  = m_pend;
    old_drain = m_drain;
    req  = stb && cyc && !m_ack && (adr[31:8] == BASE[31:8]);
    m_rd = 32'd0;
    if (req) begin
      off = adr[7:0];
      if (!we) begin
        if (off == 8'h00)      m_rd = {28'd0, m_pend};
        else if (off == 8'h04) m_rd = {16'd0, m_cnt, m_cfg, 1'b0, m_err, (m_pend != m_cfg), m_active};
        else if (off == 8'h08) m_rd = {24'd0, m_drain};
      end else begin
        if (off == 8'h00 && sel[0]) begin
          if (dat[3:0] < 4'd4) m_pend = dat[3:0];
          else m_err = 1;
        end else if (off == 8'h08 && sel[0]) m_drain = dat[7:0];
        else if (off == 8'h0C && dat[0]) m_err = 0;
      end
    end
    m_ack = req;
    edge_n++;
    if (m_active && edge_n == m_switch_at) begin
      m_cfg = old_pend;
      m_cnt = m_cnt + 8'd1;
    end else if (m_active && edge_n == m_release_at) begin
      if (m_pend != m_cfg) model_start(old_drain);
      else m_active = 0;
    end else if (!m_active && m_pend != m_cfg) begin
      model_start(old_drain);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // One request edge followed by one idle edge; returns what was seen with the ack.
  task automatic bus(input bit w, input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                     output bit got_ack, output logic [31:0] got_dat, output logic [31:0] exp_dat,
                     output bit got_oe);
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | {24'd0, off}; dat = d; sel = s;
    cycle();
    got_ack = ack; got_dat = rdat; exp_dat = m_rd; got_oe = oe;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    cycle();
  endtask

  task automatic wait_idle(output bit ok);
    for (int n = 0; n < 300 && m_active; n++) cycle();
    ok = !m_active;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit a, o; logic [31:0] d, e;
    do_reset();
    total++; if (cfg !== 4'd0 || oe !== 1'b0 || busy !== 1'b0 || ack !== 1'b0 || rdat !== 32'd0) begin
      bad++; $display("FAIL reset_outputs got cfg=%0h oe=%0b busy=%0b ack=%0b dat=%0h expected all 0", cfg, oe, busy, ack, rdat);
    end
    bus(0, 8'h04, 32'd0, 4'hF, a, d, e, o);
    total++; if (a !== 1'b1 || d !== 32'h0000_0000) begin
      bad++; $display("FAIL reset_status got ack=%0b dat=%08h expected ack=1 dat=00000000", a, d);
    end
  endtask

  task automatic test_basic_switch();
    bit a, o, ok; logic [31:0] d, e;
    bus(1, 8'h00, 32'd2, 4'hF, a, d, e, o);
    total++; if (a !== 1'b1 || o !== 1'b1) begin
      bad++; $display("FAIL basic_ack got ack=%0b oe=%0b expected 1 1", a, o);
    end
    for (int k = 1; k <= 8; k++) begin
      total++; if (oe !== (k <= 6) || cfg !== ((k >= 3) ? 4'd2 : 4'd0)) begin
        bad++; $display("FAIL basic_timeline k=%0d got oe=%0b cfg=%0h expected oe=%0b cfg=%0h",
                        k, oe, cfg, (k <= 6), (k >= 3) ? 4'd2 : 4'd0);
      end
      cycle();
    end
    wait_idle(ok);
    bus(0, 8'h04, 32'd0, 4'hF, a, d, e, o);
    total++; if (!ok || d !== 32'h0000_0120) begin
      bad++; $display("FAIL basic_status got %08h expected 00000120", d);
    end
  endtask

  task automatic test_err();
    bit a, o; logic [31:0] d, e;
    bus(1, 8'h00, 32'd7, 4'hF, a, d, e, o);
    total++; if (a !== 1'b1 || cfg !== 4'd2 || busy !== 1'b0) begin
      bad++; $display("FAIL err_drop got ack=%0b cfg=%0h busy=%0b expected 1 2 0", a, cfg, busy);
    end
    bus(0, 8'h04, 32'd0, 4'hF, a, d, e, o);
    total++; if (d[2] !== 1'b1 || d !== e) begin
      bad++; $display("FAIL err_set got %08h expected %08h", d, e);
    end
    bus(1, 8'h0C, 32'd1, 4'hF, a, d, e, o);
    bus(0, 8'h04, 32'd0, 4'hF, a, d, e, o);
    total++; if (d[2] !== 1'b0 || d !== e) begin
      bad++; $display("FAIL err_clear got %08h expected %08h", d, e);
    end
  endtask

  task automatic test_back_to_back();
    bit a, o, ok, saw1; logic [31:0] d, e;
    saw1 = 0;
    bus(1, 8'h08, 32'd4, 4'hF, a, d, e, o);
    bus(1, 8'h00, 32'd1, 4'hF, a, d, e, o);
    if (cfg === 4'd1) saw1 = 1;
    bus(1, 8'h00, 32'd3, 4'hF, a, d, e, o);
    for (int n = 0; n < 50 && m_cfg != 4'd3; n++) begin
      if (cfg === 4'd1) saw1 = 1;
      cycle();
    end
    total++; if (cfg !== 4'd3 || oe !== 1'b1) begin
      bad++; $display("FAIL b2b_first got cfg=%0h oe=%0b expected 3 1", cfg, oe);
    end
    bus(1, 8'h00, 32'd0, 4'hF, a, d, e, o);
    for (int n = 0; n < 300 && m_active; n++) begin
      if (cfg === 4'd1) saw1 = 1;
      total++; if (oe !== m_active || cfg !== m_cfg) begin
        bad++; $display("FAIL b2b_rerun got oe=%0b cfg=%0h expected %0b %0h", oe, cfg, m_active, m_cfg);
      end
      cycle();
    end
    bus(0, 8'h04, 32'd0, 4'hF, a, d, e, o);
    total++; if (saw1 || cfg !== 4'd0 || d[15:8] !== 8'd3 || d !== e) begin
      bad++; $display("FAIL b2b_final got saw1=%0b cfg=%0h status=%08h expected 0 0 %08h", saw1, cfg, d, e);
    end
  endtask

  task automatic test_reset_mid();
    bit a, o; logic [31:0] d, e;
    bus(1, 8'h00, 32'd2, 4'hF, a, d, e, o);
    total++; if (oe !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got oe=%0b expected 1", oe);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (oe !== 1'b0 || cfg !== 4'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_async got oe=%0b cfg=%0h busy=%0b expected 0 0 0", oe, cfg, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus(0, 8'h08, 32'd0, 4'hF, a, d, e, o);
    total++; if (d !== 32'd2) begin
      bad++; $display("FAIL midrst_drain got %08h expected 00000002", d);
    end
  endtask

  task automatic test_window();
    bit a, o; logic [31:0] d, e;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h100; dat = 32'd3; sel = 4'hF;
    for (int n = 0; n < 8; n++) begin
      cycle();
      total++; if (ack !== 1'b0 || cfg !== 4'd0 || oe !== 1'b0) begin
        bad++; $display("FAIL window_noack n=%0d got ack=%0b cfg=%0h oe=%0b expected 0 0 0", n, ack, cfg, oe);
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    cycle();
    bus(0, 8'h00, 32'd0, 4'hF, a, d, e, o);
    total++; if (d !== 32'd0 || d !== e) begin
      bad++; $display("FAIL window_pending got %08h expected %08h", d, e);
    end
  endtask

  task automatic test_wrap();
    bit a, o, ok; logic [31:0] d, e; logic [3:0] v;
    bus(1, 8'h08, 32'd0, 4'hF, a, d, e, o);
    for (int i = 0; i < 256; i++) begin
      v = (i % 2 == 0) ? 4'd1 : 4'd0;
      bus(1, 8'h00, {28'd0, v}, 4'hF, a, d, e, o);
      wait_idle(ok);
      total++; if (!ok || cfg !== v || busy !== 1'b0) begin
        bad++; $display("FAIL wrap_step i=%0d got cfg=%0h busy=%0b expected %0h 0", i, cfg, busy, v);
      end
    end
    bus(0, 8'h04, 32'd0, 4'hF, a, d, e, o);
    total++; if (d !== 32'd0 || d !== e) begin
      bad++; $display("FAIL wrap_status got %08h expected 00000000", d);
    end
  endtask

  task automatic test_random();
    bit a, o; logic [31:0] d, e; int op;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: bus(1, 8'h00, 32'($urandom_range(0, 3)), 4'hF, a, d, e, o);
        1: bus(1, 8'h00, 32'($urandom_range(0, 15)), 4'hF, a, d, e, o);
        2: bus(1, 8'h08, 32'($urandom_range(0, 5)), 4'hF, a, d, e, o);
        3: bus(0, 8'h04, 32'd0, 4'hF, a, d, e, o);
        4: bus(0, 8'h00, 32'd0, 4'hF, a, d, e, o);
        5: bus(1, 8'h0C, 32'($urandom_range(0, 1)), 4'hF, a, d, e, o);
        6: bus(0, 8'(4 * $urandom_range(2, 6)), 32'd0, 4'hF, a, d, e, o);
        default: begin
          for (int n = 0; n < int'($urandom_range(1, 6)); n++) begin
            cycle();
            total++; if (ack !== 1'b0 || rdat !== 32'd0) begin
              bad++; $display("FAIL rand_idle got ack=%0b dat=%08h expected 0 0", ack, rdat);
            end
          end
        end
      endcase
      if (op < 7) begin
        total++; if (a !== 1'b1 || d !== e) begin
          bad++; $display("FAIL rand_bus op=%0d got ack=%0b dat=%08h expected 1 %08h", op, a, d, e);
        end
      end
      total++; if (cfg !== m_cfg || oe !== m_active || busy !== m_active) begin
        bad++; $display("FAIL rand_state it=%0d got cfg=%0h oe=%0b busy=%0b expected %0h %0b %0b",
                        it, cfg, oe, busy, m_cfg, m_active, m_active);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_switch();
    test_err();
    test_back_to_back();
    test_reset_mid();
    test_window();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
